// File: rtl/sig_control_param_if.sv
// Signal-head bus between the intersection controller and its environment.
// x is a level request sampled at every rising clock edge; there is no
// handshake, and every other signal is a registered-state decode driven by
// the controller.
interface sig_control_param_if;
  logic       x;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic [2:0] state_o;
  logic       req_pending;
  logic       forced;

  // Environment side: drives the car sensor and watches lamps and status.
  modport master (
    output x,
    input  hwy, cntry, state_o, req_pending, forced
  );

  // Controller side.
  modport slave (
    input  x,
    output hwy, cntry, state_o, req_pending, forced
  );
endinterface

// File: rtl/sig_control_param.sv
// Highway/country-road intersection controller (Moore FSM).
// Programmable yellow, all-red and green dwell times, latched country
// requests, and a starvation guard that forces country green to end.
module sig_control_param #(
  parameter int Y2R_CYCLES      = 3,
  parameter int R2G_CYCLES      = 2,
  parameter int MIN_HWY_GREEN   = 8,
  parameter int MIN_CNTRY_GREEN = 4,
  parameter int MAX_CNTRY_GREEN = 20,
  parameter int TW              = 5
) (
  input  logic                clock,
  input  logic                clear,
  sig_control_param_if.slave  bus
);

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    CG  = 3'd3,
    CY  = 3'd4,
    AR2 = 3'd5
  } state_t;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  // Timer values at which the corresponding dwell has been served.
  localparam logic [TW-1:0] TMR_MAX      = {TW{1'b1}};
  localparam logic [TW-1:0] Y2R_LAST     = TW'(Y2R_CYCLES - 1);
  localparam logic [TW-1:0] R2G_LAST     = TW'(R2G_CYCLES - 1);
  localparam logic [TW-1:0] HWY_MIN_LAST = TW'(MIN_HWY_GREEN - 1);
  localparam logic [TW-1:0] CG_MIN_LAST  = TW'(MIN_CNTRY_GREEN - 1);
  localparam logic [TW-1:0] CG_MAX_LAST  = TW'(MAX_CNTRY_GREEN - 1);

  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] tmr_q;
  logic          req_q;
  logic          forced_q;
  logic          forced_d;

  // Next-state selection; the max-green exit outranks the normal country exit.
  always_comb begin
    state_d  = state_q;
    forced_d = 1'b0;
    case (state_q)
      HG:  if ((bus.x || req_q) && (tmr_q >= HWY_MIN_LAST)) state_d = HY;
      HY:  if (tmr_q == Y2R_LAST) state_d = AR1;
      AR1: if (tmr_q == R2G_LAST) state_d = CG;
      CG: begin
        if (tmr_q == CG_MAX_LAST) begin
          state_d  = CY;
          forced_d = 1'b1;
        end else if (!bus.x && (tmr_q >= CG_MIN_LAST)) begin
          state_d = CY;
        end
      end
      CY:  if (tmr_q == Y2R_LAST) state_d = AR2;
      AR2: if (tmr_q == R2G_LAST) state_d = HG;
      default: state_d = HG;
    endcase
  end

  // State, dwell timer, request latch and forced pulse.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= HG;
      tmr_q    <= '0;
      req_q    <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      forced_q <= forced_d;
      // Timer restarts on every state change and saturates while a state holds.
      if (state_d != state_q) begin
        tmr_q <= '0;
      end else if (tmr_q != TMR_MAX) begin
        tmr_q <= tmr_q + 1'b1;
      end
      // Entering country green serves the request, even if x is high that edge.
      if ((state_d == CG) && (state_q != CG)) begin
        req_q <= 1'b0;
      end else if (bus.x) begin
        req_q <= 1'b1;
      end
    end
  end

  // Lamp and status decode of the state register; unknown codes show all red.
  always_comb begin
    bus.hwy         = RED;
    bus.cntry       = RED;
    bus.state_o     = state_q;
    bus.req_pending = req_q;
    bus.forced      = forced_q;
    case (state_q)
      HG:      bus.hwy   = GREEN;
      HY:      bus.hwy   = YELLOW;
      CG:      bus.cntry = GREEN;
      CY:      bus.cntry = YELLOW;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sig_control_param.sv
// Directed bench for sig_control_param with default parameters.
// A cycle model predicts {state, hwy, cntry, req_pending, forced} for each
// driven cycle; predictions queue up and are compared after the edge.
module tb_sig_control_param;

  localparam int W = 9;

  logic clock;
  logic clear;

  sig_control_param_if bus ();

  sig_control_param dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  // Clock and initial input levels.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int forced_seen = 0;

  logic [W-1:0] exp_q[$];

  // Reference model state.
  int   m_state = 0;
  int   m_cnt   = 0;
  logic m_req   = 1'b0;
  logic m_forced = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] hwy_of(input int s);
    if (s == 0) return 2'd2;
    if (s == 1) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [1:0] cntry_of(input int s);
    if (s == 3) return 2'd2;
    if (s == 4) return 2'd1;
    return 2'd0;
  endfunction

  // Advance the model by one edge given the inputs seen at that edge.
  task automatic model_edge(input logic xv, input logic clr);
    int ns;
    logic f;
    if (clr) begin
      m_state = 0; m_cnt = 0; m_req = 1'b0; m_forced = 1'b0;
      return;
    end
    ns = m_state;
    f  = 1'b0;
    case (m_state)
      0: if ((xv || m_req) && m_cnt >= 7) ns = 1;
      1: if (m_cnt == 2) ns = 2;
      2: if (m_cnt == 1) ns = 3;
      3: begin
        if (m_cnt == 19) begin ns = 4; f = 1'b1; end
        else if (!xv && m_cnt >= 3) ns = 4;
      end
      4: if (m_cnt == 2) ns = 5;
      5: if (m_cnt == 1) ns = 0;
      default: ns = 0;
    endcase
    if (ns == 3 && m_state != 3) m_req = 1'b0;
    else if (xv) m_req = 1'b1;
    if (ns != m_state) m_cnt = 0;
    else if (m_cnt < 31) m_cnt = m_cnt + 1;
    m_state  = ns;
    m_forced = f;
  endtask

  // Drive one cycle, predict, then compare after the rising edge.
  task automatic step(input logic xv, input logic clr);
    logic [W-1:0] exp_v;
    logic [W-1:0] obs_v;
    @(negedge clock);
    bus.x = xv;
    clear = clr;
    model_edge(xv, clr);
    exp_q.push_back({m_state[2:0], hwy_of(m_state), cntry_of(m_state), m_req, m_forced});
    @(posedge clock);
    #1;
    obs_v = {bus.state_o, bus.hwy, bus.cntry, bus.req_pending, bus.forced};
    exp_v = exp_q.pop_front();
    chk("cycle", obs_v, exp_v);
    chk("safety", 32'((bus.hwy != 2'd0) && (bus.cntry != 2'd0)), 0);
    if (bus.forced) forced_seen++;
  endtask

  // Count cycles spent in the current state (including this one), bounded.
  task automatic dwell(input logic xv, input int limit, output int n);
    logic [2:0] s0;
    s0 = bus.state_o;
    n  = 0;
    do begin
      step(xv, 1'b0);
      n++;
    end while (bus.state_o == s0 && n < limit);
    chk("dwell_exit", 32'(bus.state_o != s0), 1);
  endtask

  initial begin
    int n;
    clear = 1'b1;
    bus.x = 1'b0;

    // Test 1: reset, then x held high for a full cycle of the intersection.
    repeat (5) step(1'b0, 1'b1);
    chk("rst_state", bus.state_o, 0);
    chk("rst_hwy", bus.hwy, 2);
    chk("rst_cntry", bus.cntry, 0);
    chk("rst_req", bus.req_pending, 0);
    chk("rst_forced", bus.forced, 0);
    forced_seen = 0;
    dwell(1'b1, 40, n); chk("t1_hg", n, 8);
    dwell(1'b1, 40, n); chk("t1_hy", n, 3);
    dwell(1'b1, 40, n); chk("t1_ar1", n, 2);
    dwell(1'b1, 40, n); chk("t1_cg", n, 20);
    chk("t1_forced", bus.forced, 1);
    dwell(1'b1, 40, n); chk("t1_cy", n, 3);
    dwell(1'b1, 40, n); chk("t1_ar2", n, 2);
    chk("t1_back_hg", bus.state_o, 0);
    chk("t1_forced_once", forced_seen, 1);

    // Test 2: single-cycle x pulse at HG tmr=2.
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("t2_req", bus.req_pending, 1);
    dwell(1'b0, 40, n); chk("t2_hg", n + 3, 8);
    dwell(1'b0, 40, n); chk("t2_hy", n, 3);
    dwell(1'b0, 40, n); chk("t2_ar1", n, 2);
    chk("t2_cg_entry", bus.state_o, 3);
    chk("t2_req_clr", bus.req_pending, 0);
    dwell(1'b0, 40, n); chk("t2_cg", n, 4);
    dwell(1'b0, 40, n); chk("t2_cy", n, 3);
    dwell(1'b0, 40, n); chk("t2_ar2", n, 2);

    // Test 3: car leaves during the 10th country-green cycle.
    dwell(1'b1, 40, n); chk("t3_hg", n, 8);
    dwell(1'b1, 40, n); chk("t3_hy", n, 3);
    dwell(1'b1, 40, n); chk("t3_ar1", n, 2);
    repeat (9) step(1'b1, 1'b0);
    chk("t3_cg_hold", bus.state_o, 3);
    step(1'b0, 1'b0);
    chk("t3_cy", bus.state_o, 4);
    chk("t3_not_forced", bus.forced, 0);

    // Test 4: long idle highway green, timer saturation.
    step(1'b0, 1'b1);
    repeat (50) step(1'b0, 1'b0);
    chk("t4_hold", bus.state_o, 0);
    chk("t4_tmr_sat", 32'(dut.tmr_q), 31);
    step(1'b1, 1'b0);
    chk("t4_hy", bus.state_o, 1);

    // Test 5: clear during AR1 mid-dwell.
    dwell(1'b0, 40, n); chk("t5_hy", n, 3);
    step(1'b0, 1'b0);
    chk("t5_ar1", bus.state_o, 2);
    step(1'b0, 1'b1);
    chk("t5_state", bus.state_o, 0);
    chk("t5_hwy", bus.hwy, 2);
    chk("t5_cntry", bus.cntry, 0);
    chk("t5_req", bus.req_pending, 0);
    repeat (20) step(1'b0, 1'b0);
    chk("t5_stay_hg", bus.state_o, 0);

    // Test 6: request latched during country yellow.
    dwell(1'b1, 40, n); chk("t6_hg_exit", n, 1);
    dwell(1'b0, 40, n); chk("t6_hy", n, 3);
    dwell(1'b0, 40, n); chk("t6_ar1", n, 2);
    dwell(1'b0, 40, n); chk("t6_cg", n, 4);
    step(1'b1, 1'b0);
    chk("t6_req", bus.req_pending, 1);
    dwell(1'b0, 40, n); chk("t6_cy_rest", n, 2);
    dwell(1'b0, 40, n); chk("t6_ar2", n, 2);
    dwell(1'b0, 40, n); chk("t6_hg", n, 8);
    chk("t6_hy", bus.state_o, 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
